sram_arbiter: RTL and testbench

//  Shares one single-port SRAM macro between NUM_REQ requesters.
//  - Arbitration: round-robin, one command per cycle.
//  - Timing: command registered to SRAM pins; fixed read latency.
//  - Init: zero-fills the array after reset and on clear_req.

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/sram_arbiter.sv | 129 ++++++++++++
 tb/tb_sram_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared state encoding, pipeline constants and helpers for the SRAM arbiter slice.
package sram_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ctrl_state_e;

  // Accept cycle to rsp_valid cycle: one for the pin register, one inside the macro.
  localparam int RD_LATENCY = 2;

  function automatic int rr_next(input int g, input int n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping.
// Zero latency; grant is all-zero when no request is pending.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_vld
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin share of one single-port SRAM; command registered to pins, read data 2 cycles after accept.
// One accept per cycle, none during the zero-fill sweep or on a clear_req cycle; responses cannot stall.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear_req,
  output logic                             init_done,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             sram_cen_n,
  output logic                             sram_gwen,
  output logic [ADDR_WIDTH-1:0]            sram_addr,
  output logic [DATA_WIDTH-1:0]            sram_wdata,
  input  logic [DATA_WIDTH-1:0]            sram_rdata
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH:0] LAST_CLR = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [NUM_REQ-1:0]  ONE_HOT0 = NUM_REQ'(1);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } sram_cmd_t;

  ctrl_state_e          state;
  logic [ADDR_WIDTH:0]  clr_cnt;
  logic [IW-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]   grant;
  logic [IW-1:0]        grant_idx;
  logic                 grant_vld;
  logic                 arb_en;
  logic                 accept;
  sram_cmd_t            cmd_sel;
  logic                 rd_s1_vld;
  logic [IW-1:0]        rd_s1_idx;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign arb_en    = (state == RUN) && !clear_req;
  assign req_ready = arb_en ? grant : '0;
  assign accept    = arb_en && grant_vld;
  assign rsp_rdata = sram_rdata;

  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IW'(i)) begin
        cmd_sel.we    = req_we[i];
        cmd_sel.addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_sel.wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      rr_ptr     <= '0;
      init_done  <= 1'b0;
      sram_cen_n <= 1'b1;
      sram_gwen  <= 1'b1;
      sram_addr  <= '0;
      sram_wdata <= '0;
      rd_s1_vld  <= 1'b0;
      rd_s1_idx  <= '0;
      rsp_valid  <= '0;
    end else begin
      // Read tag follows the command through the pin register and the macro.
      rd_s1_vld <= accept && !cmd_sel.we;
      rd_s1_idx <= grant_idx;
      rsp_valid <= rd_s1_vld ? (ONE_HOT0 << rd_s1_idx) : '0;

      case (state)
        CLEAR: begin
          sram_cen_n <= 1'b0;
          sram_gwen  <= 1'b0;
          sram_addr  <= clr_cnt[ADDR_WIDTH-1:0];
          sram_wdata <= '0;
          clr_cnt    <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_CLR) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (clear_req) begin
            state      <= CLEAR;
            init_done  <= 1'b0;
            clr_cnt    <= '0;
            sram_cen_n <= 1'b1;
            sram_gwen  <= 1'b1;
          end else if (accept) begin
            sram_cen_n <= 1'b0;
            sram_gwen  <= ~cmd_sel.we;
            sram_addr  <= cmd_sel.addr;
            sram_wdata <= cmd_sel.wdata;
            rr_ptr     <= IW'(rr_next(int'(grant_idx), NUM_REQ));
          end else begin
            sram_cen_n <= 1'b1;
            sram_gwen  <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter with a 16-entry behavioural macro and a transaction-level scoreboard.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear_req = 1'b0;
  logic              init_done;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_we = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              sram_cen_n;
  logic              sram_gwen;
  logic [AW-1:0]     sram_addr;
  logic [DW-1:0]     sram_wdata;
  logic [DW-1:0]     sram_rdata;

  sram_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .sram_cen_n(sram_cen_n), .sram_gwen(sram_gwen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Macro: 1-cycle registered read; filled with garbage while reset is held.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= {$urandom, $urandom};
    end else if (!sram_cen_n) begin
      if (!sram_gwen) mem[sram_addr] <= sram_wdata;
      else            sram_rdata <= mem[sram_addr];
    end
  end

  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] wd; } op_t;
  typedef struct { int cyc; int req; logic [DW-1:0] data; } rsp_t;
  typedef struct { int cyc; bit cen_n; bit gwen; logic [AW-1:0] addr; logic [DW-1:0] wd; } pin_t;

  op_t           opq [NR][$];
  rsp_t          exp_rsp [$];
  pin_t          exp_pin [$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            acc_order [$];
  int            acc_cyc [$];
  int            rsp3_cyc [$];
  int            rsp_cnt [NR];
  logic [DW-1:0] last_rsp [NR];
  int cyc = 0, m_ptr = 0, m_clr = 0, init_low_cnt = 0;
  int checks = 0, errors = 0;

  function automatic op_t mk_op(input bit we, input int addr, input logic [DW-1:0] wd);
    op_t o;
    o.we = we; o.addr = AW'(addr); o.wd = wd;
    return o;
  endfunction

  function automatic void schedule_sweep(input int start);
    pin_t p;
    for (int a = 0; a < DEPTH; a++) begin
      p.cyc = start + a; p.cen_n = 1'b0; p.gwen = 1'b0; p.addr = AW'(a); p.wd = '0;
      exp_pin.push_back(p);
      ref_mem[a] = '0;
    end
  endfunction

  function automatic void release_model();
    m_clr = DEPTH;
    m_ptr = 0;
    schedule_sweep(cyc + 1);
  endfunction

  function automatic bit busy();
    bit b = (exp_rsp.size() > 0) || (exp_pin.size() > 0) || (m_clr > 0);
    for (int i = 0; i < NR; i++) if (opq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      if (opq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_we[i] = opq[i][0].we;
        req_addr[i*AW +: AW] = opq[i][0].addr;
        req_wdata[i*DW +: DW] = opq[i][0].wd;
      end else begin
        req_valid[i] = 1'b0;
        req_we[i] = 1'b0;
      end
    end
  endtask

  // One clock: drive, check at negedge against the model, advance the model.
  task automatic step(input bit clr);
    int g;
    bit exp_init;
    logic [NR-1:0] exp_rdy, exp_vec;
    logic [DW-1:0] exp_dat;
    rsp_t r;
    pin_t p;
    op_t o;
    clear_req = clr;
    drive_inputs();
    @(negedge clk);
    exp_init = (m_clr == 0);
    g = -1;
    if (exp_init && !clr)
      for (int k = 0; k < NR; k++) if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    checks++;
    if (init_done !== exp_init) begin errors++; $display("FAIL init_done cyc %0d: got %b expected %b", cyc, init_done, exp_init); end
    checks++;
    if (req_ready !== exp_rdy) begin errors++; $display("FAIL req_ready cyc %0d: got %b expected %b", cyc, req_ready, exp_rdy); end
    exp_vec = '0; exp_dat = '0;
    while (exp_rsp.size() > 0 && exp_rsp[0].cyc <= cyc) begin
      r = exp_rsp.pop_front();
      if (r.cyc == cyc) begin exp_vec[r.req] = 1'b1; exp_dat = r.data; end
    end
    checks++;
    if (rsp_valid !== exp_vec) begin errors++; $display("FAIL rsp_valid cyc %0d: got %b expected %b", cyc, rsp_valid, exp_vec); end
    if (exp_vec != '0) begin
      checks++;
      if (rsp_rdata !== exp_dat) begin errors++; $display("FAIL rsp_rdata cyc %0d: got %h expected %h", cyc, rsp_rdata, exp_dat); end
    end
    for (int i = 0; i < NR; i++) if (rsp_valid[i] === 1'b1) begin
      rsp_cnt[i]++; last_rsp[i] = rsp_rdata;
      if (i == 3) rsp3_cyc.push_back(cyc);
    end
    if (init_done === 1'b0) init_low_cnt++;
    if (exp_pin.size() > 0 && exp_pin[0].cyc == cyc) begin
      p = exp_pin.pop_front();
      checks++;
      if ({sram_cen_n, sram_gwen, sram_addr, sram_wdata} !== {p.cen_n, p.gwen, p.addr, p.wd}) begin
        errors++;
        $display("FAIL sram_pins cyc %0d: got cen_n=%b gwen=%b addr=%h wdata=%h expected cen_n=%b gwen=%b addr=%h wdata=%h",
                 cyc, sram_cen_n, sram_gwen, sram_addr, sram_wdata, p.cen_n, p.gwen, p.addr, p.wd);
      end
    end else begin
      checks++;
      if (sram_cen_n !== 1'b1 || sram_gwen !== 1'b1) begin
        errors++; $display("FAIL sram_idle cyc %0d: got cen_n=%b gwen=%b expected 1 1", cyc, sram_cen_n, sram_gwen);
      end
    end
    if (g >= 0) begin
      o = opq[g][0];
      p.cyc = cyc + 1; p.cen_n = 1'b0; p.gwen = !o.we; p.addr = o.addr; p.wd = o.wd;
      exp_pin.push_back(p);
      if (o.we) ref_mem[o.addr] = o.wd;
      else begin r.cyc = cyc + RD_LATENCY; r.req = g; r.data = ref_mem[o.addr]; exp_rsp.push_back(r); end
      m_ptr = (g + 1) % NR;
      acc_order.push_back(g);
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    if (m_clr > 0) m_clr--;
    if (exp_init && clr) begin m_clr = DEPTH; schedule_sweep(cyc + 1); end
    if (g >= 0) void'(opq[g].pop_front());
    #1;
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while (busy() && n < max) begin step(1'b0); n++; end
    checks++;
    if (busy()) begin errors++; $display("FAIL run_idle: still busy after %0d cycles, expected idle", max); end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({sram_cen_n, sram_gwen, sram_addr, sram_wdata} !== {1'b1, 1'b1, {AW{1'b0}}, {DW{1'b0}}}) begin
      errors++; $display("FAIL %s_pins: got cen_n=%b gwen=%b addr=%h wdata=%h expected 1 1 0 0", tag, sram_cen_n, sram_gwen, sram_addr, sram_wdata);
    end
    checks++;
    if (rsp_valid !== '0 || init_done !== 1'b0 || req_ready !== '0) begin
      errors++; $display("FAIL %s_ctrl: got rsp_valid=%b init_done=%b req_ready=%b expected 0 0 0", tag, rsp_valid, init_done, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    release_model();
    init_low_cnt = 0;
    repeat (DEPTH + 2) step(1'b0);
    checks++;
    if (init_low_cnt != DEPTH) begin errors++; $display("FAIL reset_sweep_len: got %0d init_done-low cycles expected %0d", init_low_cnt, DEPTH); end
    for (int i = 0; i < 8; i++) opq[$urandom_range(0, NR-1)].push_back(mk_op(1'b0, $urandom_range(0, DEPTH-1), '0));
    run_idle(200);
  endtask

  task automatic test_round_robin();
    int start, base0;
    for (int a = 0; a < DEPTH; a++) opq[a % NR].push_back(mk_op(1'b1, a, {$urandom, $urandom}));
    run_idle(200);
    acc_order.delete();
    start = m_ptr;
    base0 = rsp_cnt[0];
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 5; k++) opq[i].push_back(mk_op(1'b0, $urandom_range(0, DEPTH-1), '0));
    run_idle(200);
    checks++;
    if (acc_order.size() != 5 * NR) begin errors++; $display("FAIL rr_count: got %0d accepts expected %0d", acc_order.size(), 5 * NR); end
    for (int k = 0; k < acc_order.size(); k++) begin
      checks++;
      if (acc_order[k] != (start + k) % NR) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, acc_order[k], (start + k) % NR); end
    end
    checks++;
    if (rsp_cnt[0] - base0 != 5) begin errors++; $display("FAIL rr_rsp_req0: got %0d responses expected 5", rsp_cnt[0] - base0); end
  endtask

  task automatic test_raw();
    opq[1].push_back(mk_op(1'b1, 5, 64'hDEAD_BEEF));
    step(1'b0);
    opq[2].push_back(mk_op(1'b0, 5, '0));
    run_idle(50);
    checks++;
    if (last_rsp[2] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL raw_data: got %h expected deadbeef", last_rsp[2]); end
  endtask

  task automatic test_back_to_back();
    acc_cyc.delete(); rsp3_cyc.delete(); acc_order.delete();
    for (int k = 0; k < 8; k++) opq[3].push_back(mk_op(1'b0, $urandom_range(0, DEPTH-1), '0));
    run_idle(100);
    checks++;
    if (acc_cyc.size() != 8 || acc_cyc[acc_cyc.size()-1] - acc_cyc[0] != 7) begin
      errors++; $display("FAIL b2b_accepts: got %0d accepts, not in 8 consecutive cycles", acc_cyc.size());
    end
    checks++;
    if (rsp3_cyc.size() != 8 || rsp3_cyc[rsp3_cyc.size()-1] - rsp3_cyc[0] != 7) begin
      errors++; $display("FAIL b2b_rsp: got %0d responses, not in 8 consecutive cycles", rsp3_cyc.size());
    end
    acc_order.delete();
    for (int i = 0; i < NR; i++) opq[i].push_back(mk_op(1'b0, i, '0));
    run_idle(50);
    checks++;
    if (acc_order.size() == 0 || acc_order[0] != 0) begin errors++; $display("FAIL b2b_ptr: first grant after req3 burst is not requester 0, expected 0"); end
  endtask

  task automatic test_clear_inflight();
    int base0 = rsp_cnt[0];
    opq[0].push_back(mk_op(1'b0, 5, '0));
    opq[0].push_back(mk_op(1'b0, $urandom_range(0, DEPTH-1), '0));
    step(1'b0);
    step(1'b0);
    init_low_cnt = 0;
    step(1'b1);
    for (int a = 0; a < DEPTH; a++) opq[a % NR].push_back(mk_op(1'b0, a, '0));
    repeat (5) step(1'b0);
    step(1'b1);
    run_idle(200);
    checks++;
    if (init_low_cnt != DEPTH) begin errors++; $display("FAIL clear_sweep_len: got %0d init_done-low cycles expected %0d", init_low_cnt, DEPTH); end
    checks++;
    if (rsp_cnt[0] - base0 != 2 + DEPTH / NR) begin errors++; $display("FAIL clear_inflight: got %0d req0 responses expected %0d", rsp_cnt[0] - base0, 2 + DEPTH / NR); end
  endtask

  task automatic test_async_reset();
    int total0 = 0, total1 = 0;
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 3; k++) opq[i].push_back(mk_op(1'b0, $urandom_range(0, DEPTH-1), '0));
    repeat (3) step(1'b0);
    for (int i = 0; i < NR; i++) total0 += rsp_cnt[i];
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    for (int i = 0; i < NR; i++) opq[i].delete();
    exp_rsp.delete();
    exp_pin.delete();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    release_model();
    run_idle(100);
    for (int i = 0; i < NR; i++) total1 += rsp_cnt[i];
    checks++;
    if (total1 != total0) begin errors++; $display("FAIL async_stale_rsp: got %0d responses after reset expected 0", total1 - total0); end
    for (int a = 0; a < DEPTH; a += 3) opq[a % NR].push_back(mk_op(1'b0, a, '0));
    run_idle(100);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin rsp_cnt[i] = 0; last_rsp[i] = '0; end
    test_reset();
    test_round_robin();
    test_raw();
    test_back_to_back();
    test_clear_inflight();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion before 200000");
    $fatal(1);
  end

endmodule
